// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: command-driven sequencer for the four-LED bar (D1-D4) and the
// RUN status LED (D5). A valid/ready command selects one of five fixed
// animations and its step rate. A one-cycle LOAD state seeds the pattern and
// restarts the timebase before the new animation runs.
module led_seq_ctrl #(
  parameter int unsigned TICK_DIV = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_mode,
  input  logic [3:0] cmd_speed,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic       D5
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [2:0] MODE_OFF    = 3'd0;
  localparam logic [2:0] MODE_ROT_L  = 3'd1;
  localparam logic [2:0] MODE_ROT_R  = 3'd2;
  localparam logic [2:0] MODE_BOUNCE = 3'd3;
  localparam logic [2:0] MODE_BLINK  = 3'd4;
  localparam logic [2:0] MODE_FILL   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [3:0]       speed_q, speed_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       stepcnt_q, stepcnt_d;
  logic             dir_right_q, dir_right_d;
  logic [3:0]       pat_q, pat_d;
  logic             d5_q, d5_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic             tick;
  logic             step;
  logic             mode_legal;
  logic [4:0]       next_dir_pat;

  // Pattern loaded in LOAD for a given mode; OFF and illegal modes blank the bar.
  function automatic logic [3:0] seed_of(input logic [2:0] mode);
    case (mode)
      MODE_ROT_L:  return 4'b0001;
      MODE_ROT_R:  return 4'b1000;
      MODE_BOUNCE: return 4'b0001;
      MODE_BLINK:  return 4'b1111;
      MODE_FILL:   return 4'b0000;
      default:     return 4'b0000;
    endcase
  endfunction

  // One animation step; returns {dir_right, pattern}. BOUNCE reverses at the
  // ends without dwelling on the end LED.
  function automatic logic [4:0] advance(input logic [2:0] mode,
                                         input logic [3:0] pat,
                                         input logic       dir_right);
    case (mode)
      MODE_ROT_L:  return {dir_right, pat[2:0], pat[3]};
      MODE_ROT_R:  return {dir_right, pat[0], pat[3:1]};
      MODE_BOUNCE: begin
        if (!dir_right && (pat == 4'b1000)) begin
          return {1'b1, 4'b0100};
        end else if (dir_right && (pat == 4'b0001)) begin
          return {1'b0, 4'b0010};
        end else if (dir_right) begin
          return {dir_right, 1'b0, pat[3:1]};
        end else begin
          return {dir_right, pat[2:0], 1'b0};
        end
      end
      MODE_BLINK:  return {dir_right, ~pat};
      MODE_FILL:   return (pat == 4'b1111) ? {dir_right, 4'b0000}
                                           : {dir_right, pat[2:0], 1'b1};
      default:     return {dir_right, pat};
    endcase
  endfunction

  assign accept       = cmd_valid && ready_q;
  assign tick         = (div_q == DIV_LAST);
  assign step         = tick && (stepcnt_q == speed_q);
  assign mode_legal   = (mode_q != MODE_OFF) && (mode_q <= MODE_FILL);
  assign next_dir_pat = advance(mode_q, pat_q, dir_right_q);

  // Next-state logic: command capture, LOAD seeding, timebase and stepping.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    speed_d     = speed_q;
    div_d       = div_q;
    stepcnt_d   = stepcnt_q;
    dir_right_d = dir_right_q;
    pat_d       = pat_q;
    d5_d        = d5_q;
    ready_d     = ready_q;
    case (state_q)
      ST_IDLE: begin
        div_d     = '0;
        stepcnt_d = 4'd0;
        if (accept) begin
          state_d = ST_LOAD;
          mode_d  = cmd_mode;
          speed_d = cmd_speed;
          ready_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        div_d       = '0;
        stepcnt_d   = 4'd0;
        dir_right_d = 1'b0;
        pat_d       = seed_of(mode_q);
        d5_d        = mode_legal;
        ready_d     = 1'b1;
        state_d     = mode_legal ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (accept) begin
          // Preemption: a coincident step is dropped, LOAD reseeds anyway.
          state_d = ST_LOAD;
          mode_d  = cmd_mode;
          speed_d = cmd_speed;
          ready_d = 1'b0;
        end else begin
          div_d = tick ? '0 : (div_q + DIV_W'(1));
          if (step) begin
            stepcnt_d   = 4'd0;
            dir_right_d = next_dir_pat[4];
            pat_d       = next_dir_pat[3:0];
          end else if (tick) begin
            stepcnt_d = stepcnt_q + 4'd1;
          end else begin
            stepcnt_d = stepcnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_OFF;
      speed_q     <= 4'd0;
      div_q       <= '0;
      stepcnt_q   <= 4'd0;
      dir_right_q <= 1'b0;
      pat_q       <= 4'b0000;
      d5_q        <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      div_q       <= div_d;
      stepcnt_q   <= stepcnt_d;
      dir_right_q <= dir_right_d;
      pat_q       <= pat_d;
      d5_q        <= d5_d;
      ready_q     <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign D1        = pat_q[0];
  assign D2        = pat_q[1];
  assign D3        = pat_q[2];
  assign D4        = pat_q[3];
  assign D5        = d5_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl with TICK_DIV=4: directed scenarios followed by
// random commands, compared each cycle against a closed-form reference model.
module tb_led_seq_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_speed;
  logic       D1, D2, D3, D4, D5;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     have_model = 1'b0;

  // Model state: the active command and the one before it (mode, speed, accept cycle).
  int     cur_m = 0, cur_s = 0, prv_m = 0, prv_s = 0;
  longint cur_a = -10, prv_a = -10;
  longint mark;

  led_seq_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_speed(cmd_speed),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // {D5, pattern} at cycle t for a command accepted at cycle a: k whole step
  // periods have elapsed since the seed appeared at a+2.
  function automatic logic [4:0] ref_out(input int m, input int s, input longint a, input longint t);
    longint     k;
    logic [3:0] p;
    if (m < 1 || m > 5) return 5'd0;
    k = (t - a - 64'sd2) / longint'(TD * (s + 1));
    case (m)
      1: p = 4'b0001 << 2'(k % 4);
      2: p = 4'b1000 >> 2'(k % 4);
      3: case (k % 6)
           0: p = 4'b0001;
           1: p = 4'b0010;
           2: p = 4'b0100;
           3: p = 4'b1000;
           4: p = 4'b0100;
           default: p = 4'b0010;
         endcase
      4: p = ((k % 2) == 0) ? 4'b1111 : 4'b0000;
      default: case (k % 5)
           0: p = 4'b0000;
           1: p = 4'b0001;
           2: p = 4'b0011;
           3: p = 4'b0111;
           default: p = 4'b1111;
         endcase
    endcase
    return {1'b1, p};
  endfunction

  // During LOAD the outputs freeze at the previous command's value from the accept cycle.
  function automatic logic [4:0] exp_out(input longint t);
    if (t >= cur_a + 2) return ref_out(cur_m, cur_s, cur_a, t);
    return ref_out(prv_m, prv_s, prv_a, cur_a);
  endfunction

  // One clock: check outputs of the current cycle, drive inputs, advance the model.
  task automatic tick_cycle(input logic v, input int m, input int s, input logic r);
    logic [4:0] e;
    logic       acc;
    if (have_model) begin
      e = exp_out(cyc);
      check_eq("pattern", {28'd0, D4, D3, D2, D1}, {28'd0, e[3:0]});
      check_eq("d5", {31'd0, D5}, {31'd0, e[4]});
      check_eq("cmd_ready", {31'd0, cmd_ready}, {31'd0, (cyc != cur_a + 1)});
    end
    acc = v && !r && have_model && (cyc != cur_a + 1);
    rst       = r;
    cmd_valid = v;
    cmd_mode  = 3'(m);
    cmd_speed = 4'(s);
    @(posedge clk);
    if (r) begin
      cur_m = 0; cur_s = 0; cur_a = cyc - 1;
      prv_m = 0; prv_s = 0; prv_a = cyc - 1;
      have_model = 1'b1;
    end else if (acc) begin
      prv_m = cur_m; prv_s = cur_s; prv_a = cur_a;
      cur_m = m; cur_s = s; cur_a = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_cycle(1'b0, 0, 0, 1'b0);
  endtask

  task automatic send(input int m, input int s);
    tick_cycle(1'b1, m, s, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 3'd0; cmd_speed = 4'd0;
    @(negedge clk);
    tick_cycle(1'b0, 0, 0, 1'b1);
    tick_cycle(1'b0, 0, 0, 1'b1);
    idle(20);                          // quiet after reset
    send(1, 0); idle(24);              // ROT_L, speed 0
    send(3, 1); idle(60);              // BOUNCE, speed 1
    send(5, 0); idle(14);              // FILL ...
    send(4, 0); idle(12);              // ... preempted by BLINK
    send(1, 1); idle(5);
    send(7, 0); idle(10);              // illegal mode from RUN -> IDLE
    send(2, 0); send(4, 0); idle(6);   // second command lands in LOAD, not accepted
    mark = cyc;
    send(1, 0);                        // step edges end cycles mark+5, mark+9, ...
    idle(int'(mark + 9 - cyc));
    send(2, 0); idle(10);              // accept on a step edge
    send(3, 0); idle(7);
    tick_cycle(1'b1, 5, 2, 1'b1);      // reset with a command in the same cycle
    idle(10);
    for (int n = 0; n < 40; n++) begin
      tick_cycle(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 30) == 0));
      idle(int'($urandom_range(0, 40)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Command-driven sequencer for the four-LED bar (D1–D4) plus status LED D5 on the iCE board top level. It owns the step prescaler and pattern register, and accepts mode/speed commands over a valid/ready handshake. It runs one of five fixed animations until the next command arrives. Blocks that only need to say "show pattern X at speed Y" drive it instead of each carrying their own divider and shift register.

## Interface
- TICK_DIV, 120000: base tick period in clk cycles (10 ms at 12 MHz); legal range 2..2^24.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_mode  in  3  0 OFF, 1 ROT_L, 2 ROT_R, 3 BOUNCE, 4 BLINK, 5 FILL; 6–7 illegal.
- cmd_speed  in  4  a step occurs every (cmd_speed+1) ticks.
- D1..D4  out  1 each  pattern bits pat[0]..pat[3]; registered.
- D5  out  1  high while the state is RUN; registered.

## Operation
- States: IDLE (mode OFF), LOAD (single cycle), RUN.
- A command is accepted on any cycle with cmd_valid && cmd_ready. mode and speed are latched at that point and stay constant until the next acceptance.
- IDLE or RUN, on accept -> LOAD. LOAD -> RUN if the latched mode is 1..5; LOAD -> IDLE if it is 0, 6 or 7.
- Illegal modes 6/7 are accepted and behave exactly as OFF.
- In LOAD: cmd_ready = 0, divider = 0, stepcnt = 0, dir = left, and pat is loaded with the seed. Seeds: ROT_L 0001, ROT_R 1000, BOUNCE 0001, BLINK 1111, FILL 0000, OFF 0000.
- cmd_ready is 1 in IDLE and RUN. cmd_ready is 0 only in LOAD.
- Divider counts 0..TICK_DIV-1 and wraps. tick = (divider == TICK_DIV-1).
- On tick, stepcnt increments. step = tick && (stepcnt == speed); on a step, stepcnt returns to 0.
- Divider and stepcnt are held at 0 in IDLE.
- On a step, by mode:
  - ROT_L: pat <= {pat[2:0], pat[3]}.
  - ROT_R: pat <= {pat[0], pat[3:1]}.
  - BOUNCE: shift one position in direction dir. At 1000 with dir=left, set dir=right and go to 0100. At 0001 with dir=right, set dir=left and go to 0010. There is no dwell at the ends.
  - BLINK: pat <= ~pat.
  - FILL: pat <= {pat[2:0], 1} until 1111; 1111 -> 0000.
- An accept in RUN preempts the current animation immediately; no step completes after the accept cycle.
- If an accept coincides with a step edge, the accept wins: LOAD follows and the step is discarded.

## Timing
- Reset values: state IDLE, pat 0000 (D1–D4 low), D5 0, cmd_ready 1, mode OFF, speed 0, divider 0, stepcnt 0, dir left.
- rst overrides everything, including an accept in the same cycle. If rst is asserted mid-animation, the block is in the reset state on the following cycle.
- Accept at cycle A:
  - LOAD is in cycle A+1 with cmd_ready low.
  - Seed is visible on D1–D4 in cycle A+2.
  - D5 rises in A+2 when entering RUN, or falls in A+2 when entering IDLE.
  - cmd_ready is high again in A+2.
- First step is visible at cycle A+2+TICK_DIV*(speed+1). Later steps follow every TICK_DIV*(speed+1) cycles.
- Back-to-back commands: at most one accept per two cycles, because LOAD always blocks.

## Test plan
- Reset, then hold cmd_valid=0 -> D1–D5 = 0 and cmd_ready = 1 indefinitely; divider stays idle.
- TICK_DIV=4. Accept ROT_L with speed 0 at cycle A -> cmd_ready low at A+1. D1–D4 read 0001 at A+2, then 0010 at A+6, 0100 at A+10, 1000 at A+14, 0001 at A+18. D5 = 1 from A+2.
- TICK_DIV=4, BOUNCE, speed 1 -> pattern sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, with changes every 8 cycles.
- FILL, then BLINK -> FILL sequence 0000, 0001, 0011, 0111, 1111, 0000. BLINK accepted mid-FILL reloads 1111 at A+2 and then alternates 0000/1111.
- Accept cmd_mode=7 while in RUN -> LOAD then IDLE. Pattern 0000, D5 = 0, divider frozen.
- Collision cases:
  - Accept on the exact step-edge cycle -> no step is applied; seed appears at A+2.
  - rst asserted together with cmd_valid in mid-RUN -> all outputs at reset values next cycle; command ignored.
